// File: rtl/i2cmb_cmd_sequencer.sv
// Runs one I2CMB command per request over a Wishbone master port:
// DPR write when needed, CMDR write, wait for irq, CMDR read, optional DPR read, response.
module i2cmb_cmd_sequencer #(
  parameter int unsigned ADDR_WIDTH     = 2,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            req_cmd_i,
  input  logic [7:0]            req_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [3:0]            rsp_status_o,
  output logic [7:0]            rsp_data_o,
  output logic                  rsp_rsvd_err_o,
  output logic                  rsp_timeout_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic                  ack_i,
  input  logic                  irq_i
);

  typedef enum logic [2:0] {
    IDLE, WR_DPR, WR_CMDR, WAIT_IRQ, RD_CMDR, RD_DPR, RSP
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADR_DPR  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADR_CMDR = ADDR_WIDTH'(2);
  localparam logic [16:0]           TMO_MAX  = 17'(TIMEOUT_CYCLES);

  state_t                r_state;
  logic [2:0]            r_cmd;
  logic [7:0]            r_data;
  logic [15:0]           r_cnt;
  logic                  r_cyc;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [DATA_WIDTH-1:0] r_dat;
  logic                  r_valid;
  logic [3:0]            r_status;
  logic [7:0]            r_rdata;
  logic                  r_rsvd;
  logic                  r_tmo;
  logic [16:0]           w_cnt_nxt;
  logic                  w_tmo;

  assign w_cnt_nxt = {1'b0, r_cnt} + 17'd1;
  assign w_tmo     = (w_cnt_nxt == TMO_MAX);

  // Every bus state raises cyc/stb on its first cycle and drops them on ack,
  // so back-to-back transfers are always separated by one idle bus cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= IDLE;
      r_cmd    <= '0;
      r_data   <= '0;
      r_cnt    <= '0;
      r_cyc    <= 1'b0;
      r_we     <= 1'b0;
      r_adr    <= '0;
      r_dat    <= '0;
      r_valid  <= 1'b0;
      r_status <= '0;
      r_rdata  <= '0;
      r_rsvd   <= 1'b0;
      r_tmo    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (req_valid_i) begin
          r_cmd    <= req_cmd_i;
          r_data   <= req_data_i;
          r_status <= '0;
          r_rdata  <= '0;
          r_rsvd   <= 1'b0;
          r_tmo    <= 1'b0;
          if (req_cmd_i == 3'b111) begin
            r_status <= 4'b0001;
            r_valid  <= 1'b1;
            r_state  <= RSP;
          end else if (req_cmd_i == 3'b001 || req_cmd_i == 3'b110) begin
            r_state <= WR_DPR;
          end else begin
            r_state <= WR_CMDR;
          end
        end
        WR_DPR: if (!r_cyc) begin
          r_cyc <= 1'b1;
          r_we  <= 1'b1;
          r_adr <= ADR_DPR;
          r_dat <= DATA_WIDTH'(r_data);
        end else if (ack_i) begin
          r_cyc   <= 1'b0;
          r_state <= WR_CMDR;
        end
        WR_CMDR: if (!r_cyc) begin
          r_cyc <= 1'b1;
          r_we  <= 1'b1;
          r_adr <= ADR_CMDR;
          r_dat <= DATA_WIDTH'({5'b0, r_cmd});
        end else if (ack_i) begin
          r_cyc   <= 1'b0;
          r_cnt   <= '0;
          r_state <= WAIT_IRQ;
        end
        WAIT_IRQ: begin
          r_cnt <= w_cnt_nxt[15:0];
          if (irq_i) begin
            r_state <= RD_CMDR;
          end else if (w_tmo) begin
            r_tmo   <= 1'b1;
            r_state <= RD_CMDR;
          end
        end
        RD_CMDR: if (!r_cyc) begin
          r_cyc <= 1'b1;
          r_we  <= 1'b0;
          r_adr <= ADR_CMDR;
        end else if (ack_i) begin
          r_cyc    <= 1'b0;
          r_status <= dat_i[7:4];
          r_rsvd   <= dat_i[3];
          if ((r_cmd == 3'b010 || r_cmd == 3'b011) && dat_i[7]) begin
            r_state <= RD_DPR;
          end else begin
            r_valid <= 1'b1;
            r_state <= RSP;
          end
        end
        RD_DPR: if (!r_cyc) begin
          r_cyc <= 1'b1;
          r_we  <= 1'b0;
          r_adr <= ADR_DPR;
        end else if (ack_i) begin
          r_cyc   <= 1'b0;
          r_rdata <= dat_i[7:0];
          r_valid <= 1'b1;
          r_state <= RSP;
        end
        RSP: if (rsp_ready_i) begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready_o    = (r_state == IDLE);
  assign rsp_valid_o    = r_valid;
  assign rsp_status_o   = r_status;
  assign rsp_data_o     = r_rdata;
  assign rsp_rsvd_err_o = r_rsvd;
  assign rsp_timeout_o  = r_tmo;
  assign cyc_o          = r_cyc;
  assign stb_o          = r_cyc;
  assign we_o           = r_we;
  assign adr_o          = r_adr;
  assign dat_o          = r_dat;

endmodule

// File: tb/tb_i2cmb_cmd_sequencer.sv
// Directed bench for i2cmb_cmd_sequencer: a vector table of commands against a
// behavioural Wishbone/I2CMB slave, plus hand-written reset and corner sequences.
module tb_i2cmb_cmd_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       req_valid_i, req_ready_o;
  logic [2:0] req_cmd_i;
  logic [7:0] req_data_i;
  logic       rsp_valid_o, rsp_ready_i;
  logic [3:0] rsp_status_o;
  logic [7:0] rsp_data_o;
  logic       rsp_rsvd_err_o, rsp_timeout_o;
  logic       cyc_o, stb_o, we_o;
  logic [1:0] adr_o;
  logic [7:0] dat_o, dat_i;
  logic       ack_i, irq_i;

  i2cmb_cmd_sequencer #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_cmd_i(req_cmd_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_status_o(rsp_status_o), .rsp_data_o(rsp_data_o),
    .rsp_rsvd_err_o(rsp_rsvd_err_o), .rsp_timeout_o(rsp_timeout_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
    .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0] cmd;
    logic [7:0] data;
    int         ack_dly;
    int         irq_dly;   // irq rises in this WAIT_IRQ cycle (1-based); 0 = never
    logic [7:0] cmdr;
    logic [7:0] dpr;
    logic [3:0] e_status;
    logic [7:0] e_data;
    logic       e_rsvd;
    logic       e_to;
    int         e_dpr_wr;
    int         e_dpr_rd;
    logic [7:0] e_cmdr_wdat;
    logic [7:0] e_dpr_wdat;
  } vec_t;

  vec_t vecs[9];

  int n_cmp = 0, n_err = 0;
  int cyc_n = 0, wcnt = 0, wr_ack_c = 0;
  int ack_dly = 0, irq_dly = 0;
  int n_dpr_wr, n_dpr_rd, n_cmdr_wr, n_cmdr_rd;
  int bus_cyc = 0, rsp_cyc = 0, stab_err = 0;
  logic       irq_arm = 1'b0, in_xfer = 1'b0;
  logic [7:0] cmdr_val, dpr_val, cmdr_wdat, dpr_wdat;
  logic [1:0] s_adr;
  logic       s_we;
  logic [7:0] s_dat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural slave: acks after ack_dly cycles, models irq and checks bus stability.
  initial begin
    ack_i = 1'b0; irq_i = 1'b0; dat_i = '0;
    forever begin
      @(posedge clk_i); #1;
      cyc_n++;
      if (rsp_valid_o) rsp_cyc++;
      if (cyc_o) bus_cyc++;
      if (irq_arm && irq_dly != 0 && cyc_n == wr_ack_c + irq_dly) irq_i = 1'b1;
      if (ack_i) begin
        ack_i = 1'b0;
      end else if (cyc_o && stb_o) begin
        if (!in_xfer) begin
          in_xfer = 1'b1; s_adr = adr_o; s_we = we_o; s_dat = dat_o;
        end else if (s_adr !== adr_o || s_we !== we_o || (we_o && s_dat !== dat_o)) begin
          stab_err++;
        end
        if (wcnt >= ack_dly) begin
          ack_i = 1'b1; wcnt = 0; in_xfer = 1'b0;
          if (we_o && adr_o == 2'd1) begin
            n_dpr_wr++; dpr_wdat = dat_o;
          end else if (we_o && adr_o == 2'd2) begin
            n_cmdr_wr++; cmdr_wdat = dat_o; wr_ack_c = cyc_n; irq_arm = 1'b1;
          end else if (!we_o && adr_o == 2'd2) begin
            n_cmdr_rd++; dat_i = cmdr_val; irq_i = 1'b0; irq_arm = 1'b0;
          end else if (!we_o && adr_o == 2'd1) begin
            n_dpr_rd++; dat_i = dpr_val;
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0; in_xfer = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic run_vec(input int i);
    vec_t v;
    logic got;
    logic [14:0] cap;
    v = vecs[i];
    ack_dly = v.ack_dly; irq_dly = v.irq_dly; cmdr_val = v.cmdr; dpr_val = v.dpr;
    n_dpr_wr = 0; n_dpr_rd = 0; n_cmdr_wr = 0; n_cmdr_rd = 0;
    cmdr_wdat = '0; dpr_wdat = '0;
    for (int k = 0; k < 50 && !req_ready_o; k++) begin @(posedge clk_i); #1; end
    chk($sformatf("v%0d req_ready", i), req_ready_o, 1);
    req_valid_i = 1'b1; req_cmd_i = v.cmd; req_data_i = v.data;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (rsp_valid_o) begin got = 1'b1; break; end
      @(posedge clk_i); #1;
    end
    chk($sformatf("v%0d rsp_valid", i), got, 1);
    if (got) begin
      cap = {rsp_status_o, rsp_data_o, rsp_rsvd_err_o, rsp_timeout_o, rsp_valid_o};
      @(posedge clk_i); #1;
      chk($sformatf("v%0d rsp_hold", i),
          {rsp_status_o, rsp_data_o, rsp_rsvd_err_o, rsp_timeout_o, rsp_valid_o}, cap);
      chk($sformatf("v%0d status", i), rsp_status_o, v.e_status);
      chk($sformatf("v%0d data", i), rsp_data_o, v.e_data);
      chk($sformatf("v%0d rsvd_err", i), rsp_rsvd_err_o, v.e_rsvd);
      chk($sformatf("v%0d timeout", i), rsp_timeout_o, v.e_to);
      chk($sformatf("v%0d dpr_writes", i), n_dpr_wr, v.e_dpr_wr);
      chk($sformatf("v%0d dpr_reads", i), n_dpr_rd, v.e_dpr_rd);
      chk($sformatf("v%0d cmdr_writes", i), n_cmdr_wr, 1);
      chk($sformatf("v%0d cmdr_reads", i), n_cmdr_rd, 1);
      chk($sformatf("v%0d cmdr_wdat", i), cmdr_wdat, v.e_cmdr_wdat);
      if (v.e_dpr_wr != 0) chk($sformatf("v%0d dpr_wdat", i), dpr_wdat, v.e_dpr_wdat);
      rsp_ready_i = 1'b1;
      @(posedge clk_i); #1;
      rsp_ready_i = 1'b0;
      chk($sformatf("v%0d rsp_drop", i), rsp_valid_o, 0);
      chk($sformatf("v%0d back_idle", i), req_ready_o, 1);
    end
  endtask

  initial begin
    logic got;
    //          cmd     data   ack irq cmdr   dpr    st       data   rs  to  dw dr cmdr_w dpr_w
    vecs[0] = '{3'b001, 8'hA5, 2, 10, 8'h80, 8'h00, 4'b1000, 8'h00, 0, 0, 1, 0, 8'h01, 8'hA5};
    vecs[1] = '{3'b010, 8'h00, 1,  5, 8'h80, 8'h3C, 4'b1000, 8'h3C, 0, 0, 0, 1, 8'h02, 8'h00};
    vecs[2] = '{3'b100, 8'h00, 0,  0, 8'h00, 8'h00, 4'b0000, 8'h00, 0, 1, 0, 0, 8'h04, 8'h00};
    vecs[3] = '{3'b011, 8'h00, 2,  3, 8'h48, 8'h77, 4'b0100, 8'h00, 1, 0, 0, 0, 8'h03, 8'h00};
    vecs[4] = '{3'b110, 8'h07, 0,  1, 8'h80, 8'h00, 4'b1000, 8'h00, 0, 0, 1, 0, 8'h06, 8'h07};
    vecs[5] = '{3'b010, 8'h00, 1,  4, 8'h20, 8'h99, 4'b0010, 8'h00, 0, 0, 0, 0, 8'h02, 8'h00};
    vecs[6] = '{3'b011, 8'h00, 3,  2, 8'h90, 8'h5A, 4'b1001, 8'h5A, 0, 0, 0, 1, 8'h03, 8'h00};
    vecs[7] = '{3'b101, 8'h00, 0, 16, 8'h80, 8'h00, 4'b1000, 8'h00, 0, 0, 0, 0, 8'h05, 8'h00};
    vecs[8] = '{3'b101, 8'h00, 0, 17, 8'h80, 8'h00, 4'b1000, 8'h00, 0, 1, 0, 0, 8'h05, 8'h00};

    rst_i = 1'b0; req_valid_i = 1'b0; req_cmd_i = '0; req_data_i = '0; rsp_ready_i = 1'b0;
    cmdr_val = '0; dpr_val = '0;
    #1;
    chk("reset outputs",
        {cyc_o, stb_o, we_o, adr_o, dat_o, rsp_valid_o, rsp_status_o, rsp_data_o,
         rsp_rsvd_err_o, rsp_timeout_o}, '0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i); rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("ready after reset", req_ready_o, 1);

    for (int i = 0; i < 9; i++) run_vec(i);

    // Reserved command: immediate error response, no bus traffic, no new acceptance.
    bus_cyc = 0;
    req_valid_i = 1'b1; req_cmd_i = 3'b111;
    @(posedge clk_i); #1;
    chk("c111 rsp_valid", rsp_valid_o, 1);
    chk("c111 status", rsp_status_o, 4'b0001);
    chk("c111 not ready", req_ready_o, 0);
    req_cmd_i = 3'b001;
    repeat (3) begin @(posedge clk_i); #1; end
    chk("c111 held", {rsp_valid_o, rsp_status_o, req_ready_o}, 6'b1_0001_0);
    req_valid_i = 1'b0; rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    chk("c111 no bus", bus_cyc, 0);
    chk("c111 idle", req_ready_o, 1);

    // Reset during the CMDR write with the slave stalling.
    ack_dly = 50; irq_dly = 0;
    req_valid_i = 1'b1; req_cmd_i = 3'b100;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (stb_o && adr_o == 2'd2) begin got = 1'b1; break; end
      @(posedge clk_i); #1;
    end
    chk("rst WR_CMDR reached", got, 1);
    #2 rst_i = 1'b0;
    #1;
    chk("rst drops bus", {cyc_o, stb_o}, 2'b00);
    @(negedge clk_i); rst_i = 1'b1;
    rsp_cyc = 0; bus_cyc = 0;
    @(posedge clk_i); #1;
    chk("rst ready", req_ready_o, 1);
    repeat (30) @(posedge clk_i);
    #1;
    chk("rst no response", rsp_cyc, 0);
    chk("rst no bus", bus_cyc, 0);
    chk("bus stability", stab_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2cmb_cmd_sequencer.md
I2CMB_CMD_SEQUENCER -- requirements
Module: i2cmb_cmd_sequencer

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 2, Wishbone address width; DATA_WIDTH, default 8, Wishbone data width; TIMEOUT_CYCLES, default 65535, maximum number of cycles to wait for irq_i.
REQ-002 clk_i  input  1  single system clock; all logic on rising edge.
REQ-003 rst_i  input  1  asynchronous, active-low reset.
REQ-004 req_valid_i  input  1  command request valid.
REQ-005 req_ready_o  output  1  sequencer can accept a request.
REQ-006 req_cmd_i  input  3  I2CMB command code.
REQ-007 req_data_i  input  8  byte for the write or set_bus command.
REQ-008 rsp_valid_o  output  1  response valid.
REQ-009 rsp_ready_i  input  1  response consumed.
REQ-010 rsp_status_o  output  4  {don, nak, al, err} captured from CMDR.
REQ-011 rsp_data_o  output  8  DPR byte returned by read commands.
REQ-012 rsp_rsvd_err_o  output  1  CMDR reserved bit 3 was read as 1.
REQ-013 rsp_timeout_o  output  1  irq_i did not arrive within TIMEOUT_CYCLES.
REQ-014 cyc_o, stb_o, we_o  output  1 each  Wishbone master strobes.
REQ-015 adr_o  output  ADDR_WIDTH  register address: CSR=0, DPR=1, CMDR=2, FSMR=3.
REQ-016 dat_o  output  DATA_WIDTH  write data.
REQ-017 dat_i  input  DATA_WIDTH  read data.
REQ-018 ack_i  input  1  Wishbone acknowledge.
REQ-019 irq_i  input  1  I2CMB command-complete interrupt.

Function
REQ-020 The FSM states SHALL be IDLE, WR_DPR, WR_CMDR, WAIT_IRQ, RD_CMDR, RD_DPR and RSP.
REQ-021 req_ready_o SHALL be high only in IDLE; a request is accepted on a cycle where req_valid_i and req_ready_o are both high, and cmd/data are registered on that cycle.
REQ-022 On acceptance, the next state SHALL be:
- WR_DPR for write (001) or set_bus (110);
- RSP for code 111, with status 0001 (err) and no bus activity;
- WR_CMDR for all other codes.
REQ-023 Each bus state SHALL perform one classic Wishbone single transfer:
- cyc_o and stb_o are high from state entry until the cycle ack_i is sampled high;
- cyc_o and stb_o are low on the following cycle;
- adr_o, we_o and dat_o are stable for the whole transfer.
REQ-024 WR_DPR SHALL write req_data to DPR (we_o=1, adr_o=1) and then go to WR_CMDR.
REQ-025 WR_CMDR SHALL write {5'b0, cmd} to CMDR (adr_o=2) and then go to WAIT_IRQ.
REQ-026 WAIT_IRQ behaviour:
- A 16-bit counter is cleared on entry and increments each cycle.
- The FSM leaves for RD_CMDR when irq_i=1, or when the counter reaches TIMEOUT_CYCLES, which also sets the timeout flag.
- If irq_i=1 on the same cycle the counter reaches TIMEOUT_CYCLES, irq_i wins and the timeout flag stays 0.
REQ-027 RD_CMDR SHALL read CMDR (we_o=0, adr_o=2) and latch on ack_i:
- dat_i[7:4] into status;
- dat_i[3] into rsvd_err.
A CMDR read is always issued, even on timeout, so that irq_i is cleared.
REQ-028 After RD_CMDR the FSM SHALL go to RD_DPR if cmd is read_ack (010) or read_nak (011) and don=1, otherwise to RSP.
REQ-029 RD_DPR SHALL read DPR (adr_o=1), latch dat_i into rsp_data_o, and go to RSP.
REQ-030 rsp_data_o SHALL hold 8'h00 for any command that does not perform RD_DPR.
REQ-031 In RSP:
- rsp_valid_o=1, and all rsp_* outputs hold stable until rsp_ready_i=1;
- the FSM returns to IDLE on the cycle after the handshake.
REQ-032 At most one command SHALL be in flight; no new request is accepted until the response handshake completes.
REQ-033 ack_i sampled while cyc_o=0 SHALL be ignored.
REQ-034 irq_i outside WAIT_IRQ SHALL be ignored.
REQ-035 There SHALL be no ack timeout; the FSM waits in a bus state indefinitely.

Reset
REQ-036 Asserting rst_i low SHALL asynchronously force:
- state to IDLE;
- cyc_o, stb_o, we_o, rsp_valid_o, rsp_rsvd_err_o and rsp_timeout_o to 0;
- adr_o, dat_o, rsp_status_o and rsp_data_o to 0;
- the WAIT_IRQ counter to 0.
REQ-037 Reset asserted mid-transfer SHALL drop cyc_o/stb_o immediately without completing the transfer; no response is produced for the aborted command.
REQ-038 req_ready_o SHALL be 1 on the first clock edge after rst_i deasserts.

Verification
REQ-039 write cmd=001, data=8'hA5; ack after 2 cycles; irq_i after 10 cycles; CMDR reads 8'h80 -> DPR write 8'hA5, CMDR write 8'h01, CMDR read, rsp_status_o=1000, rsp_data_o=8'h00.
REQ-040 read_ack cmd=010; CMDR reads 8'h80; DPR reads 8'h3C -> no DPR write; rsp_data_o=8'h3C.
REQ-041 start cmd=100; irq_i never asserts; TIMEOUT_CYCLES=16 -> CMDR read issued after 16 WAIT_IRQ cycles; rsp_timeout_o=1.
REQ-042 CMDR reads 8'h48 -> rsp_status_o=0100 (nak), rsp_rsvd_err_o=1.
REQ-043 cmd=111 -> no cyc_o activity; rsp_status_o=0001 on the cycle after acceptance.
REQ-044 rst_i low during WR_CMDR with stb_o high -> cyc_o=stb_o=0 immediately; req_ready_o=1 after release; no rsp_valid_o.
